// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter: access sizes, sequencer
// states and requester IDs.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (A fetch, B load/store) and memory-side signals.
// master = core + memory instance side, slave = the arbiter.
interface mem_port_arbiter_if #(
    parameter int MEM_ADDR_BITS = 20
);
    logic                     a_req;
    logic [31:0]              a_addr;
    logic                     a_ack;
    logic [31:0]              a_rdata;

    logic                     b_req;
    logic                     b_we;
    logic [1:0]               b_size;
    logic                     b_unsigned;
    logic [31:0]              b_addr;
    logic [31:0]              b_wdata;
    logic                     b_ack;
    logic [31:0]              b_rdata;
    logic                     b_err;

    logic [MEM_ADDR_BITS-1:0] m_addr;
    logic [31:0]              m_wdata;
    logic                     m_str;
    logic [3:0]               m_sel;
    logic                     m_ld;
    logic [31:0]              m_rdata;

    modport master (
        output a_req, a_addr,
        input  a_ack, a_rdata,
        output b_req, b_we, b_size, b_unsigned, b_addr, b_wdata,
        input  b_ack, b_rdata, b_err,
        input  m_addr, m_wdata, m_str, m_sel, m_ld,
        output m_rdata
    );

    modport slave (
        input  a_req, a_addr,
        output a_ack, a_rdata,
        input  b_req, b_we, b_size, b_unsigned, b_addr, b_wdata,
        output b_ack, b_rdata, b_err,
        output m_addr, m_wdata, m_str, m_sel, m_ld,
        input  m_rdata
    );

endinterface

// File: rtl/mem_lane_steer.sv
// Combinational byte-lane steering: store replication + byte enables, and
// load right-alignment with sign/zero extension.
module mem_lane_steer
    import mem_port_arbiter_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  off,
    input  logic        zext,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_raw,
    output logic [3:0]  sel,
    output logic [31:0] st_lanes,
    output logic [31:0] ld_data
);
    logic [4:0]  shamt;
    logic [31:0] shifted;

    // Half accesses look only at off[1]; word and reserved sizes ignore off.
    always_comb begin
        sel      = 4'b1111;
        st_lanes = st_data;
        shamt    = 5'd0;
        case (size)
            SZ_BYTE: begin
                sel      = 4'b0001 << off;
                st_lanes = {4{st_data[7:0]}};
                shamt    = {off, 3'b000};
            end
            SZ_HALF: begin
                sel      = off[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{st_data[15:0]}};
                shamt    = {off[1], 4'b0000};
            end
            default: ;
        endcase
    end

    assign shifted = ld_raw >> shamt;

    always_comb begin
        ld_data = shifted;
        case (size)
            SZ_BYTE: ld_data = {{24{~zext & shifted[7]}},  shifted[7:0]};
            SZ_HALF: ld_data = {{16{~zext & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin IDLE/ACCESS/RESP sequencer sharing one byte-lane memory between
// fetch port A and load/store port B. Define MEM_PORT_ARBITER_ALIGN_CHECK_EN for b_err.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 20,
    parameter int MEM_DATA_BITS = 32
) (
    input  logic               clk,
    input  logic               clr,
    mem_port_arbiter_if.slave  bus
);
    localparam int LANES = MEM_DATA_BITS / 8;

    state_e                   state_q, state_d;
    port_e                    port_q, last_q;
    logic                     we_q, uns_q, err_q;
    size_e                    size_q;
    logic [1:0]               off_q;

    logic [MEM_ADDR_BITS-1:0] m_addr_q;
    logic [31:0]              m_wdata_q;
    logic [LANES-1:0]         m_sel_q;
    logic                     m_str_q, m_ld_q;

    logic                     a_win, b_win, b_mis, grant;
    size_e                    b_sz, st_size;
    logic [1:0]               st_off;
    logic                     st_uns;
    logic [3:0]               st_sel;
    logic [31:0]              st_lanes, ld_data;
    logic                     unused_ok;

    assign unused_ok = ^{bus.a_addr, bus.b_addr};
    assign b_sz      = size_e'(bus.b_size);

    // Under contention the port that did not win last time goes next.
    always_comb begin
        a_win = 1'b0;
        b_win = 1'b0;
        if (bus.a_req && bus.b_req) begin
            if (last_q == PORT_B) a_win = 1'b1;
            else                  b_win = 1'b1;
        end else if (bus.a_req) begin
            a_win = 1'b1;
        end else if (bus.b_req) begin
            b_win = 1'b1;
        end
    end
    assign grant = (state_q == IDLE) && (a_win || b_win);

`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
    assign b_mis = (b_sz == SZ_RSVD) ||
                   (b_sz == SZ_HALF && bus.b_addr[0]) ||
                   (b_sz == SZ_WORD && bus.b_addr[1:0] != 2'b00);
`else
    assign b_mis = 1'b0;
`endif

    // One steering instance: live request fields in IDLE, latched ones in RESP.
    always_comb begin
        if (state_q == IDLE) begin
            st_size = a_win ? SZ_WORD : b_sz;
            st_off  = a_win ? bus.a_addr[1:0] : bus.b_addr[1:0];
            st_uns  = bus.b_unsigned;
        end else begin
            st_size = size_q;
            st_off  = off_q;
            st_uns  = uns_q;
        end
    end

    mem_lane_steer u_steer (
        .size     (st_size),
        .off      (st_off),
        .zext     (st_uns),
        .st_data  (bus.b_wdata),
        .ld_raw   (bus.m_rdata),
        .sel      (st_sel),
        .st_lanes (st_lanes),
        .ld_data  (ld_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (a_win || b_win) state_d = (b_win && b_mis) ? RESP : ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Memory strobes are loaded on the grant edge so they are live only in ACCESS.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            port_q    <= PORT_A;
            last_q    <= PORT_B;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            err_q     <= 1'b0;
            size_q    <= SZ_WORD;
            off_q     <= 2'b00;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_sel_q   <= '0;
            m_str_q   <= 1'b0;
            m_ld_q    <= 1'b0;
        end else begin
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_sel_q   <= '0;
            m_str_q   <= 1'b0;
            m_ld_q    <= 1'b0;
            if (grant) begin
                port_q <= a_win ? PORT_A : PORT_B;
                last_q <= a_win ? PORT_A : PORT_B;
                we_q   <= b_win & bus.b_we;
                uns_q  <= st_uns;
                err_q  <= b_win & b_mis;
                size_q <= st_size;
                off_q  <= st_off;
                if (!(b_win && b_mis)) begin
                    m_addr_q  <= a_win ? bus.a_addr[MEM_ADDR_BITS+1:2]
                                       : bus.b_addr[MEM_ADDR_BITS+1:2];
                    m_wdata_q <= (b_win && bus.b_we) ? st_lanes : 32'h0;
                    m_sel_q   <= st_sel;
                    m_str_q   <= b_win & bus.b_we;
                    m_ld_q    <= ~(b_win & bus.b_we);
                end
            end
        end
    end

    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_sel   = m_sel_q;
    assign bus.m_str   = m_str_q;
    assign bus.m_ld    = m_ld_q;

    assign bus.a_ack   = (state_q == RESP) && (port_q == PORT_A);
    assign bus.b_ack   = (state_q == RESP) && (port_q == PORT_B);
    assign bus.b_err   = bus.b_ack && err_q;
    assign bus.a_rdata = bus.a_ack ? ld_data : 32'h0;
    assign bus.b_rdata = (bus.b_ack && !we_q && !err_q) ? ld_data : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a synchronous byte-lane memory model.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic clr;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.MEM_ADDR_BITS(20)) bus();

    mem_port_arbiter #(.MEM_ADDR_BITS(20), .MEM_DATA_BITS(32)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    logic [31:0] mem [0:255];
    logic [31:0] mdout;
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mdout = 32'h0;
    end
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.m_str && bus.m_sel[i]) mem[bus.m_addr[7:0]][8*i +: 8] <= bus.m_wdata[8*i +: 8];
            if (bus.m_ld) mdout[8*i +: 8] <= bus.m_sel[i] ? mem[bus.m_addr[7:0]][8*i +: 8] : 8'h00;
        end
    end
    assign bus.m_rdata = mdout;

    int          r_lat;
    logic [3:0]  r_sel;
    logic [19:0] r_maddr;
    logic [31:0] r_mwd, r_rd;
    logic        r_str, r_ld, r_err, r_memop;

    task automatic b_xact(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        @(posedge clk); #1;
        bus.b_req = 1'b1; bus.b_we = we; bus.b_size = sz; bus.b_unsigned = uns;
        bus.b_addr = addr; bus.b_wdata = wd;
        r_lat = -1; r_sel = '0; r_maddr = '0; r_mwd = '0; r_rd = '0;
        r_str = 1'b0; r_ld = 1'b0; r_err = 1'b0; r_memop = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.m_str || bus.m_ld) begin
                r_memop = 1'b1; r_sel = bus.m_sel; r_maddr = bus.m_addr;
                r_mwd = bus.m_wdata; r_str = bus.m_str; r_ld = bus.m_ld;
            end
            if (bus.b_ack) begin r_lat = c; r_rd = bus.b_rdata; r_err = bus.b_err; break; end
        end
        @(posedge clk); #1;
        bus.b_req = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        bus.a_req = 1'b0; bus.a_addr = 32'h0;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_size = 2'b10; bus.b_unsigned = 1'b0;
        bus.b_addr = 32'h10; bus.b_wdata = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.a_ack, bus.b_ack, bus.b_err, bus.m_str, bus.m_ld} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000", {bus.a_ack, bus.b_ack, bus.b_err, bus.m_str, bus.m_ld});
        end
        checks++;
        if ({bus.m_sel, bus.m_addr, bus.m_wdata, bus.a_rdata, bus.b_rdata} !== '0) begin
            errors++; $display("FAIL reset_buses got sel=%h addr=%h wd=%h ard=%h brd=%h want all 0",
                               bus.m_sel, bus.m_addr, bus.m_wdata, bus.a_rdata, bus.b_rdata);
        end
        bus.b_req = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic test_word();
        b_xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL st_word_lat got %0d want 2", r_lat); end
        checks++;
        if ({r_sel, r_maddr, r_str, r_ld} !== {4'b1111, 20'd4, 1'b1, 1'b0}) begin
            errors++; $display("FAIL st_word_mem got sel=%b addr=%0d str=%b ld=%b want 1111 4 1 0", r_sel, r_maddr, r_str, r_ld);
        end
        checks++; if (r_mwd !== 32'hDEADBEEF) begin errors++; $display("FAIL st_word_wdata got %h want deadbeef", r_mwd); end
        checks++; if (r_rd !== 32'h0) begin errors++; $display("FAIL st_word_rdata got %h want 0", r_rd); end
        b_xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL ld_word_lat got %0d want 2", r_lat); end
        checks++;
        if ({r_sel, r_maddr, r_str, r_ld} !== {4'b1111, 20'd4, 1'b0, 1'b1}) begin
            errors++; $display("FAIL ld_word_mem got sel=%b addr=%0d str=%b ld=%b want 1111 4 0 1", r_sel, r_maddr, r_str, r_ld);
        end
        checks++; if (r_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_word_rdata got %h want deadbeef", r_rd); end
    endtask

    task automatic test_byte();
        b_xact(1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080);
        checks++; if (r_sel !== 4'b1000) begin errors++; $display("FAIL st_byte_sel got %b want 1000", r_sel); end
        checks++; if (r_mwd !== 32'h80808080) begin errors++; $display("FAIL st_byte_wdata got %h want 80808080", r_mwd); end
        b_xact(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        checks++; if (r_rd !== 32'hFFFFFF80) begin errors++; $display("FAIL ld_byte_s got %h want ffffff80", r_rd); end
        b_xact(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        checks++; if (r_rd !== 32'h00000080) begin errors++; $display("FAIL ld_byte_u got %h want 00000080", r_rd); end
        b_xact(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        checks++; if (r_rd !== 32'h000000BE) begin errors++; $display("FAIL ld_byte_off1 got %h want 000000be", r_rd); end
    endtask

    task automatic test_half();
        b_xact(1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234);
        checks++;
        if ({r_sel, r_maddr} !== {4'b1100, 20'd8}) begin
            errors++; $display("FAIL st_half_sel got sel=%b addr=%0d want 1100 8", r_sel, r_maddr);
        end
        checks++; if (r_mwd !== 32'h12341234) begin errors++; $display("FAIL st_half_wdata got %h want 12341234", r_mwd); end
        b_xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        checks++; if (r_rd !== 32'h12340000) begin errors++; $display("FAIL ld_half_word got %h want 12340000", r_rd); end
        b_xact(1'b1, 2'b01, 1'b0, 32'h20, 32'hAAAABEEF);
        checks++; if (r_sel !== 4'b0011) begin errors++; $display("FAIL st_half_lo_sel got %b want 0011", r_sel); end
        b_xact(1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
        checks++; if (r_rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL ld_half_s got %h want ffffbeef", r_rd); end
        b_xact(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
        checks++; if (r_rd !== 32'h00001234) begin errors++; $display("FAIL ld_half_hi got %h want 00001234", r_rd); end
    endtask

    task automatic test_align();
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
        b_xact(1'b0, 2'b01, 1'b0, 32'h21, 32'h0);
        checks++; if (r_lat !== 1) begin errors++; $display("FAIL mis_half_lat got %0d want 1", r_lat); end
        checks++;
        if ({r_err, r_memop, r_rd} !== {1'b1, 1'b0, 32'h0}) begin
            errors++; $display("FAIL mis_half got err=%b memop=%b rd=%h want 1 0 0", r_err, r_memop, r_rd);
        end
        b_xact(1'b1, 2'b10, 1'b0, 32'h22, 32'h55555555);
        checks++;
        if ({r_lat, r_err, r_memop} !== {32'd1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL mis_word got lat=%0d err=%b memop=%b want 1 1 0", r_lat, r_err, r_memop);
        end
        b_xact(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
        checks++;
        if ({r_lat, r_err, r_memop} !== {32'd1, 1'b1, 1'b0}) begin
            errors++; $display("FAIL rsvd_size got lat=%0d err=%b memop=%b want 1 1 0", r_lat, r_err, r_memop);
        end
`else
        b_xact(1'b0, 2'b01, 1'b1, 32'h21, 32'h0);
        checks++;
        if ({r_lat, r_err, r_sel} !== {32'd2, 1'b0, 4'b0011}) begin
            errors++; $display("FAIL nochk_half got lat=%0d err=%b sel=%b want 2 0 0011", r_lat, r_err, r_sel);
        end
        checks++; if (r_rd !== 32'h0000BEEF) begin errors++; $display("FAIL nochk_half_rd got %h want 0000beef", r_rd); end
        b_xact(1'b0, 2'b11, 1'b0, 32'h22, 32'h0);
        checks++;
        if ({r_err, r_sel, r_rd} !== {1'b0, 4'b1111, 32'h1234BEEF}) begin
            errors++; $display("FAIL nochk_rsvd got err=%b sel=%b rd=%h want 0 1111 1234beef", r_err, r_sel, r_rd);
        end
`endif
    endtask

    task automatic test_contention();
        int n;
        int cyc [4];
        logic [3:0] who;
        logic [31:0] ard, brd;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        n = 0; who = '0; ard = '0; brd = '0;
        bus.a_req = 1'b1; bus.a_addr = 32'h10;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_size = 2'b10; bus.b_unsigned = 1'b0; bus.b_addr = 32'h20;
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus.a_ack && bus.b_ack) begin errors++; $display("FAIL both_ack at cycle %0d got 1 1 want one", c); end
            if (bus.a_ack || bus.b_ack) begin
                cyc[n] = c; who[n] = bus.b_ack;
                if (bus.a_ack) ard = bus.a_rdata; else brd = bus.b_rdata;
                n++;
            end
        end
        @(posedge clk); #1;
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL rr_ack_count got %0d want 4", n);
        end else begin
            checks++; if (who !== 4'b1010) begin errors++; $display("FAIL rr_order got %b want 1010 (B-bits, A first)", who); end
            checks++;
            if ({cyc[0], cyc[1], cyc[2], cyc[3]} !== {32'd2, 32'd5, 32'd8, 32'd11}) begin
                errors++; $display("FAIL rr_timing got %0d %0d %0d %0d want 2 5 8 11", cyc[0], cyc[1], cyc[2], cyc[3]);
            end
        end
        checks++; if (ard !== 32'h80ADBEEF) begin errors++; $display("FAIL rr_a_rdata got %h want 80adbeef", ard); end
        checks++; if (brd !== 32'h1234BEEF) begin errors++; $display("FAIL rr_b_rdata got %h want 1234beef", brd); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(posedge clk); #1;
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_size = 2'b10; bus.b_addr = 32'h30; bus.b_wdata = 32'hCAFEF00D;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.m_str !== 1'b1) begin errors++; $display("FAIL mid_access_str got %b want 1", bus.m_str); end
        #1 clr = 1'b1;
        #1;
        checks++;
        if ({bus.m_str, bus.m_ld, bus.m_sel, bus.m_addr, bus.m_wdata, bus.b_ack, bus.a_ack} !== '0) begin
            errors++; $display("FAIL mid_clr_outputs got str=%b sel=%b addr=%h wd=%h ack=%b want all 0",
                               bus.m_str, bus.m_sel, bus.m_addr, bus.m_wdata, bus.b_ack);
        end
        seen = 1'b0;
        repeat (3) begin @(negedge clk); seen |= bus.b_ack | bus.m_str; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_clr_no_ack got %b want 0", seen); end
        @(posedge clk); #1;
        clr = 1'b0; bus.b_req = 1'b0;
        @(posedge clk); #1;
        bus.a_req = 1'b1; bus.a_addr = 32'h10;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 32'h20;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.b_ack) seen = 1'b1;
            if (bus.a_ack) begin
                checks++; if (c !== 2) begin errors++; $display("FAIL post_clr_a_lat got %0d want 2", c); end
                break;
            end
        end
        checks++;
        if ({seen, bus.a_ack} !== 2'b01) begin errors++; $display("FAIL post_clr_first got bseen=%b aack=%b want 0 1", seen, bus.a_ack); end
        @(posedge clk); #1;
        bus.a_req = 1'b0; bus.b_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_align();
        test_contention();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
